// File: rtl/issueque_int.sv
// Integer issue queue: age-ordered, compacting reservation station that snoops
// the CDB and issues the oldest fully-ready op onto a registered ALU input bus.

module issueque_int_opnd #(
    parameter int TAGW = 6
) (
    input  logic            en_i,
    input  logic            rdy_i,
    input  logic [TAGW-1:0] tag_i,
    input  logic [31:0]     data_i,
    input  logic            cdb_valid_i,
    input  logic [TAGW-1:0] cdb_tag_i,
    input  logic [31:0]     cdb_data_i,
    output logic            rdy_o,
    output logic [31:0]     data_o
);
    logic hit;

    // Only pending operands capture the broadcast; ready values are never overwritten.
    assign hit    = en_i & ~rdy_i & cdb_valid_i & (tag_i == cdb_tag_i);
    assign rdy_o  = rdy_i | hit;
    assign data_o = hit ? cdb_data_i : data_i;
endmodule

module issueque_int #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dispatch_en,
    input  logic [3:0]      dispatch_opcode,
    input  logic [TAGW-1:0] dispatch_rstag,
    input  logic [31:0]     dispatch_rsdata,
    input  logic            dispatch_rsvalid,
    input  logic [TAGW-1:0] dispatch_rttag,
    input  logic [31:0]     dispatch_rtdata,
    input  logic            dispatch_rtvalid,
    input  logic [TAGW-1:0] dispatch_rdtag,
    output logic            issueque_full,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [31:0]     cdb_data,
    input  logic            issue_stall,
    input  logic            flush,
    output logic            issueint_valid,
    output logic [3:0]      issueint_opcode,
    output logic [31:0]     issueint_rsdata,
    output logic [31:0]     issueint_rtdata,
    output logic [TAGW-1:0] issueint_rdtag
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            valid;
        logic [3:0]      opcode;
        logic [TAGW-1:0] rstag;
        logic [31:0]     rsdata;
        logic            rsrdy;
        logic [TAGW-1:0] rttag;
        logic [31:0]     rtdata;
        logic            rtrdy;
        logic [TAGW-1:0] rdtag;
    } ent_t;

    ent_t [DEPTH-1:0]       ent_q, ent_d, ent_w;
    ent_t [DEPTH:0]         ent_x;
    ent_t                   disp_ent, sel_ent;
    logic [CW-1:0]          count_q, count_d, cnt_after;
    logic                   full_q, full_d;
    logic                   out_vld_q, out_vld_d;
    logic [3:0]             out_op_q, out_op_d;
    logic [31:0]            out_rs_q, out_rs_d;
    logic [31:0]            out_rt_q, out_rt_d;
    logic [TAGW-1:0]        out_rd_q, out_rd_d;
    logic [DEPTH-1:0]       rdy_vec, wk_rsrdy, wk_rtrdy;
    logic [DEPTH-1:0][31:0] wk_rsdata, wk_rtdata;
    logic [IW-1:0]          sel_idx;
    logic                   any_rdy, issue, accept;
    logic                   byp_rsrdy, byp_rtrdy;
    logic [31:0]            byp_rsdata, byp_rtdata;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        issueque_int_opnd #(.TAGW(TAGW)) u_rs (
            .en_i(ent_q[g].valid), .rdy_i(ent_q[g].rsrdy), .tag_i(ent_q[g].rstag),
            .data_i(ent_q[g].rsdata), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_data_i(cdb_data), .rdy_o(wk_rsrdy[g]), .data_o(wk_rsdata[g])
        );
        issueque_int_opnd #(.TAGW(TAGW)) u_rt (
            .en_i(ent_q[g].valid), .rdy_i(ent_q[g].rtrdy), .tag_i(ent_q[g].rttag),
            .data_i(ent_q[g].rtdata), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_data_i(cdb_data), .rdy_o(wk_rtrdy[g]), .data_o(wk_rtdata[g])
        );
    end

    // Same-cycle bypass for the dispatching op's pending operands.
    issueque_int_opnd #(.TAGW(TAGW)) u_byp_rs (
        .en_i(1'b1), .rdy_i(dispatch_rsvalid), .tag_i(dispatch_rstag),
        .data_i(dispatch_rsdata), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_data_i(cdb_data), .rdy_o(byp_rsrdy), .data_o(byp_rsdata)
    );
    issueque_int_opnd #(.TAGW(TAGW)) u_byp_rt (
        .en_i(1'b1), .rdy_i(dispatch_rtvalid), .tag_i(dispatch_rttag),
        .data_i(dispatch_rtdata), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_data_i(cdb_data), .rdy_o(byp_rtrdy), .data_o(byp_rtdata)
    );

    always_comb begin
        disp_ent        = '0;
        disp_ent.valid  = 1'b1;
        disp_ent.opcode = dispatch_opcode;
        disp_ent.rstag  = dispatch_rstag;
        disp_ent.rsdata = byp_rsdata;
        disp_ent.rsrdy  = byp_rsrdy;
        disp_ent.rttag  = dispatch_rttag;
        disp_ent.rtdata = byp_rtdata;
        disp_ent.rtrdy  = byp_rtrdy;
        disp_ent.rdtag  = dispatch_rdtag;
    end

    // Readiness uses registered state only, so a wakeup is visible one cycle later.
    always_comb begin
        rdy_vec = '0;
        sel_idx = '0;
        sel_ent = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_vec[i] = ent_q[i].valid & ent_q[i].rsrdy & ent_q[i].rtrdy;
            if (rdy_vec[i]) begin
                sel_idx = IW'(i);
                sel_ent = ent_q[i];
            end
        end
        any_rdy = |rdy_vec;
        issue   = any_rdy & ~issue_stall & ~flush;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_w[i]        = ent_q[i];
            ent_w[i].rsrdy  = wk_rsrdy[i];
            ent_w[i].rsdata = wk_rsdata[i];
            ent_w[i].rtrdy  = wk_rtrdy[i];
            ent_w[i].rtdata = wk_rtdata[i];
        end
        ent_x[DEPTH-1:0] = ent_w;
        ent_x[DEPTH]     = '0;
    end

    // Compact over the issued slot, then append the new op at the new tail.
    always_comb begin
        accept    = dispatch_en & ~full_q & ~flush;
        cnt_after = count_q - CW'(issue);
        ent_d     = ent_w;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && (IW'(i) >= sel_idx)) ent_d[i] = ent_x[i+1];
            else                              ent_d[i] = ent_x[i];
            if (accept && (CW'(i) == cnt_after)) ent_d[i] = disp_ent;
            if (flush) ent_d[i].valid = 1'b0;
        end
        count_d = flush ? '0 : cnt_after + CW'(accept);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_op_d  = out_op_q;
        out_rs_d  = out_rs_q;
        out_rt_d  = out_rt_q;
        out_rd_d  = out_rd_q;
        if (flush) begin
            out_vld_d = 1'b0;
        end else if (!issue_stall) begin
            out_vld_d = any_rdy;
            if (any_rdy) begin
                out_op_d = sel_ent.opcode;
                out_rs_d = sel_ent.rsdata;
                out_rt_d = sel_ent.rtdata;
                out_rd_d = sel_ent.rdtag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q     <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            out_vld_q <= 1'b0;
            out_op_q  <= '0;
            out_rs_q  <= '0;
            out_rt_q  <= '0;
            out_rd_q  <= '0;
        end else begin
            ent_q     <= ent_d;
            count_q   <= count_d;
            full_q    <= full_d;
            out_vld_q <= out_vld_d;
            out_op_q  <= out_op_d;
            out_rs_q  <= out_rs_d;
            out_rt_q  <= out_rt_d;
            out_rd_q  <= out_rd_d;
        end
    end

    assign issueque_full   = full_q;
    assign issueint_valid  = out_vld_q;
    assign issueint_opcode = out_op_q;
    assign issueint_rsdata = out_rs_q;
    assign issueint_rtdata = out_rt_q;
    assign issueint_rdtag  = out_rd_q;
endmodule
